dice_roller: RTL and testbench

- Upstream stage of the dice game controller. Produces its Rb and Sum inputs and consumes its Roll output.
- Debounces the raw roll pushbutton into a clean Rb level.
- Runs two odometer-linked 1..6 die counters while Roll is high, and presents Sum = Die1 + Die2 to the controller.
- Flags a settled result and keeps a saturating count of completed rolls.

---
 rtl/dice_roller_if.sv | 26 ++
 rtl/dice_roller.sv | 164 ++++++++++++++++
 tb/tb_dice_roller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dice_roller_if.sv
// Roll-side bus of the dice roller: raw button and roll enable in,
// debounced button, dice faces, sum, settle flag and roll count out.
interface dice_roller_if #(
  parameter int COUNT_W = 8
);
  logic               Btn;
  logic               Roll;
  logic               Rb;
  logic [3:0]         Sum;
  logic [2:0]         Die1;
  logic [2:0]         Die2;
  logic               SumValid;
  logic [COUNT_W-1:0] RollCount;

  // Dice roller side
  modport slave (
    input  Btn, Roll,
    output Rb, Sum, Die1, Die2, SumValid, RollCount
  );

  // Game controller / stimulus side
  modport master (
    output Btn, Roll,
    input  Rb, Sum, Die1, Die2, SumValid, RollCount
  );
endinterface

// File: rtl/dice_roller.sv
// Dice roller: debounces the roll pushbutton into Rb, runs two
// odometer-linked 1..6 dice while Roll is high, and reports the settled
// sum together with a saturating count of completed rolls.
module dice_roller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int COUNT_W         = 8
) (
  input  logic          CLK,
  input  logic          Reset,
  dice_roller_if.slave  bus
);

  localparam int DC_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DC_W-1:0]    DC_ZERO   = DC_W'(1'b0);
  localparam logic [DC_W-1:0]    DC_ONE    = DC_W'(1'b1);
  localparam logic [DC_W-1:0]    DC_LAST   = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_ZERO  = COUNT_W'(1'b0);
  localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1'b1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLED = 2'd2
  } state_t;

  logic            s1_r;
  logic            s2_r;
  logic [DC_W-1:0] dc_r;
  logic            rb_r;
  logic [2:0]      die1_r;
  logic [2:0]      die2_r;
  logic [3:0]      sum_s;
  state_t          state_r;
  state_t          next_state_s;
  logic            sum_valid_s;
  logic            roll_done_s;
  logic [COUNT_W-1:0] roll_count_r;

  // Two-flop synchronizer for the asynchronous pushbutton
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= bus.Btn;
      s2_r <= s1_r;
    end
  end

  // Debouncer: Rb follows s2 only after DEBOUNCE_CYCLES consecutive mismatching edges
  always_ff @(posedge CLK) begin
    if (Reset) begin
      rb_r <= 1'b0;
      dc_r <= DC_ZERO;
    end else if (s2_r == rb_r) begin
      dc_r <= DC_ZERO;
    end else if (dc_r == DC_LAST) begin
      rb_r <= s2_r;
      dc_r <= DC_ZERO;
    end else begin
      dc_r <= dc_r + DC_ONE;
    end
  end

  // Odometer dice: Die1 steps on every Roll edge, Die2 steps when Die1 wraps
  always_ff @(posedge CLK) begin
    if (Reset) begin
      die1_r <= 3'd1;
      die2_r <= 3'd1;
    end else if (bus.Roll) begin
      if (die1_r == 3'd6) begin
        die1_r <= 3'd1;
        die2_r <= (die2_r == 3'd6) ? 3'd1 : (die2_r + 3'd1);
      end else begin
        die1_r <= die1_r + 3'd1;
      end
    end
  end

  // Roll FSM state register
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Roll FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.Roll) begin
          next_state_s = ROLLING;
        end else begin
          next_state_s = IDLE;
        end
      end
      ROLLING: begin
        if (bus.Roll) begin
          next_state_s = ROLLING;
        end else begin
          next_state_s = SETTLED;
        end
      end
      SETTLED: begin
        if (bus.Roll) begin
          next_state_s = ROLLING;
        end else begin
          next_state_s = SETTLED;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Roll FSM Moore outputs and roll-completion strobe
  always_comb begin
    sum_valid_s = 1'b0;
    roll_done_s = 1'b0;
    case (state_r)
      SETTLED: begin
        sum_valid_s = 1'b1;
      end
      ROLLING: begin
        if (!bus.Roll) begin
          roll_done_s = 1'b1;
        end else begin
          roll_done_s = 1'b0;
        end
      end
      default: begin
        sum_valid_s = 1'b0;
        roll_done_s = 1'b0;
      end
    endcase
  end

  // Saturating count of completed rolls
  always_ff @(posedge CLK) begin
    if (Reset) begin
      roll_count_r <= CNT_ZERO;
    end else if (roll_done_s && (roll_count_r != CNT_MAX)) begin
      roll_count_r <= roll_count_r + CNT_ONE;
    end
  end

  // Sum of the two faces; zero-extended so 6+6 fits
  always_comb begin
    sum_s = {1'b0, die1_r} + {1'b0, die2_r};
  end

  assign bus.Rb        = rb_r;
  assign bus.Die1      = die1_r;
  assign bus.Die2      = die2_r;
  assign bus.Sum       = sum_s;
  assign bus.SumValid  = sum_valid_s;
  assign bus.RollCount = roll_count_r;

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: directed scenarios plus a random run
// against a behavioural model (roll index 0..35, mismatch run length).
module tb_dice_roller;

  localparam int DEB = 4;

  logic CLK = 1'b0;
  logic Reset;

  dice_roller_if #(.COUNT_W(8)) bus8();
  dice_roller_if #(.COUNT_W(2)) bus2();

  assign bus2.Btn  = bus8.Btn;
  assign bus2.Roll = bus8.Roll;

  dice_roller #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(8)) dut8 (
    .CLK(CLK), .Reset(Reset), .bus(bus8.slave)
  );

  dice_roller #(.DEBOUNCE_CYCLES(DEB), .COUNT_W(2)) dut2 (
    .CLK(CLK), .Reset(Reset), .bus(bus2.slave)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model
  bit m_prev1, m_prev2, m_rb;
  int m_run, m_k, m_state, m_cnt;

  function automatic logic [22:0] exp_vec();
    int d1, d2, c8, c2;
    d1 = (m_k % 6) + 1;
    d2 = (m_k / 6) + 1;
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    return {m_rb, 4'(d1 + d2), 3'(d1), 3'(d2), (m_state == 2), 8'(c8), 2'(c2), (m_state == 2)};
  endfunction

  task automatic tick(input bit rst, input bit btn, input bit roll);
    Reset     = rst;
    bus8.Btn  = btn;
    bus8.Roll = roll;
    @(posedge CLK);
    if (rst) begin
      m_prev1 = 1'b0; m_prev2 = 1'b0; m_rb = 1'b0;
      m_run = 0; m_k = 0; m_state = 0; m_cnt = 0;
    end else begin
      if (m_prev2 != m_rb) begin
        m_run++;
        if (m_run == DEB) begin
          m_rb  = m_prev2;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_prev2 = m_prev1;
      m_prev1 = btn;
      if (roll) m_k = (m_k + 1) % 36;
      case (m_state)
        0: if (roll) m_state = 1;
        1: if (!roll) begin m_state = 2; m_cnt++; end
        2: if (roll) m_state = 1;
        default: m_state = 0;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({bus8.Rb, bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid, bus8.RollCount, bus2.RollCount}
        !== {1'b0, 3'd1, 3'd1, 4'd2, 1'b0, 8'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_state got rb=%0b d1=%0d d2=%0d sum=%0d v=%0b c8=%0d c2=%0d exp 0 1 1 2 0 0 0",
               bus8.Rb, bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid, bus8.RollCount, bus2.RollCount);
    end
  endtask

  task automatic test_debounce();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (bus8.Rb !== (i == 5)) begin
        n_fail++;
        $display("FAIL debounce_rise edge+%0d got %0b exp %0b", i, bus8.Rb, (i == 5));
      end
    end
    for (int i = 0; i <= 5; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus8.Rb !== (i != 5)) begin
        n_fail++;
        $display("FAIL debounce_fall edge+%0d got %0b exp %0b", i, bus8.Rb, (i != 5));
      end
    end
  endtask

  task automatic test_glitch();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if (bus8.Rb !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_hold cyc %0d got %0b exp 0", i, bus8.Rb);
      end
    end
    // A fresh press must still need the full debounce count
    for (int i = 0; i <= 5; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      n_tests++;
      if (bus8.Rb !== (i == 5)) begin
        n_fail++;
        $display("FAIL glitch_recount edge+%0d got %0b exp %0b", i, bus8.Rb, (i == 5));
      end
    end
  endtask

  task automatic test_roll8();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid} !== {3'd3, 3'd2, 4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL roll8_dice got d1=%0d d2=%0d sum=%0d v=%0b exp 3 2 5 0",
               bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid);
    end
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid, bus8.RollCount} !== {3'd3, 3'd2, 4'd5, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL roll8_settle got d1=%0d d2=%0d sum=%0d v=%0b cnt=%0d exp 3 2 5 1 1",
               bus8.Die1, bus8.Die2, bus8.Sum, bus8.SumValid, bus8.RollCount);
    end
  endtask

  task automatic test_wrap();
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.Sum} !== {3'd6, 3'd6, 4'd12}) begin
      n_fail++;
      $display("FAIL wrap35 got d1=%0d d2=%0d sum=%0d exp 6 6 12", bus8.Die1, bus8.Die2, bus8.Sum);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.Sum} !== {3'd1, 3'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL wrap36 got d1=%0d d2=%0d sum=%0d exp 1 1 2", bus8.Die1, bus8.Die2, bus8.Sum);
    end
  endtask

  task automatic test_reset_midroll();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 1'b1);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.RollCount} !== {3'd4, 3'd3, 8'd1}) begin
      n_fail++;
      $display("FAIL midroll_pre got d1=%0d d2=%0d cnt=%0d exp 4 3 1", bus8.Die1, bus8.Die2, bus8.RollCount);
    end
    tick(1'b1, 1'b1, 1'b1);
    n_tests++;
    if ({bus8.Die1, bus8.Die2, bus8.SumValid, bus8.RollCount, bus8.Rb} !== {3'd1, 3'd1, 1'b0, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL midroll_reset got d1=%0d d2=%0d v=%0b cnt=%0d rb=%0b exp 1 1 0 0 0",
               bus8.Die1, bus8.Die2, bus8.SumValid, bus8.RollCount, bus8.Rb);
    end
    // Back in IDLE: a zero-Roll edge must not settle
    tick(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bus8.SumValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midroll_idle got v=%0b exp 0", bus8.SumValid);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp2 [5];
    exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    tick(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (bus2.SumValid !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_rolling pulse %0d got v=%0b exp 0", p, bus2.SumValid);
      end
      tick(1'b0, 1'b0, 1'b0);
      n_tests++;
      if ({bus2.SumValid, bus2.RollCount, bus8.RollCount} !== {1'b1, exp2[p], 8'(p + 1)}) begin
        n_fail++;
        $display("FAIL sat_count pulse %0d got v=%0b c2=%0d c8=%0d exp 1 %0d %0d",
                 p, bus2.SumValid, bus2.RollCount, bus8.RollCount, exp2[p], p + 1);
      end
      tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_random();
    bit btn, roll;
    logic [22:0] got;
    btn = 1'b0;
    roll = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if ($urandom_range(0, 3) == 0) roll = ~roll;
      tick(($urandom_range(0, 79) == 0), btn, roll);
      got = {bus8.Rb, bus8.Sum, bus8.Die1, bus8.Die2, bus8.SumValid, bus8.RollCount,
             bus2.RollCount, bus2.SumValid};
      n_tests++;
      if (got !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d got %h exp %h", i, got, exp_vec());
      end
    end
  endtask

  initial begin
    Reset     = 1'b1;
    bus8.Btn  = 1'b0;
    bus8.Roll = 1'b0;
    test_reset();
    test_debounce();
    test_glitch();
    test_roll8();
    test_wrap();
    test_reset_midroll();
    test_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
